// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: state codes,
// opcodes, and the ALUOp codes handed to the ALU control decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    IMMEX   = 4'd9,
    IMMWB   = 4'd10,
    JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_ANDI = 6'd12;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam logic [2:0] ALUOP_FUNCT = 3'd1;
  localparam logic [2:0] ALUOP_ADD   = 3'd2;
  localparam logic [2:0] ALUOP_SLT   = 3'd3;
  localparam logic [2:0] ALUOP_AND   = 3'd4;
  localparam logic [2:0] ALUOP_OR    = 3'd5;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction,
// drives mux selects/strobes, stalls on MemReady and counts retired instructions.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic             Eq,
  input  logic             MemReady,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             ZeroExt,
  output logic [2:0]       ALUOp,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount,
  output logic [3:0]       State
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               retire;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // NOTE: every output and next-state term gets a default first, so no latches are inferred.
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 2'b00;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ZeroExt   = 1'b0;
    ALUOp     = ALUOP_ADD;
    IllegalOp = 1'b0;

    unique case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW:                       state_d = MEMADR;
          OP_R:                               state_d = RTYPEEX;
          OP_BEQ:                             state_d = BEQEX;
          OP_J:                               state_d = JEX;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  state_d = IMMEX;
          default: begin
            IllegalOp = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_d = MEMWB;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      RTYPEEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
        state_d = RTYPEWB;
      end
      RTYPEWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      BEQEX: begin
        ALUSrcA = 1'b1;
        PCSrc   = 2'b01;
        PCWrite = Eq;
        retire  = 1'b1;
        state_d = FETCH;
      end
      IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (Op)
          OP_SLTI: ALUOp = ALUOP_SLT;
          OP_ANDI: ALUOp = ALUOP_AND;
          OP_ORI:  ALUOp = ALUOP_OR;
          default: ALUOp = ALUOP_ADD;
        endcase
        ZeroExt = (Op == OP_ANDI) || (Op == OP_ORI);
        state_d = IMMWB;
      end
      IMMWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      JEX: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Reset is synchronous for the registers, but strobes must be quiet for the whole reset window.
    if (reset) begin
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      IllegalOp = 1'b0;
    end
  end

  assign count_d    = count_q + {{(CNT_W-1){1'b0}}, retire};
  assign InstrCount = count_q;
  assign State      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: a per-instruction reference model pushes
// the expected output vector for every cycle; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] state;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [2:0] aluop;
    logic       illegal;
    logic [3:0] count;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       Eq;
  logic       MemReady;
  logic       IRWrite, PCWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg;
  logic       ALUSrcA, ZeroExt, IllegalOp;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUOp;
  logic [3:0] InstrCount;
  logic [3:0] State;

  mips_multicycle_ctrl #(.CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Eq         (Eq),
    .MemReady   (MemReady),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ZeroExt    (ZeroExt),
    .ALUOp      (ALUOp),
    .IllegalOp  (IllegalOp),
    .InstrCount (InstrCount),
    .State      (State)
  );

  always #5 clk = ~clk;

  vec_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] m_count = 4'd0;

  vec_t act;
  assign act = '{State, IRWrite, PCWrite, PCSrc, IorD, MemRead, MemWrite, RegWrite, RegDst,
                 MemtoReg, ALUSrcA, ALUSrcB, ZeroExt, ALUOp, IllegalOp, InstrCount};

  task automatic check(input vec_t got, input vec_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL cycle_vec%0d state=%0d: actual=%h required=%h", vectors, want.state, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check(act, exp_q.pop_front());
  end

  function automatic vec_t blank(input int s);
    vec_t e;
    e       = '0;
    e.state = 4'(s);
    e.aluop = 3'd2;
    e.count = m_count;
    return e;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One architectural step; wait steps may be preceded by MemReady=0 stall cycles.
  task automatic step(input vec_t e, input bit is_wait, input int nstall, input bit eq);
    int   n;
    vec_t s;
    n = nstall;
    if (!is_wait) n = 0;
    else if (n < 0) n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
    for (int i = 0; i < n; i++) begin
      s = e;
      if (e.state == 4'd0) begin
        s.irwrite = 1'b0;
        s.pcwrite = 1'b0;
      end
      s.count  = m_count;
      Eq       = 1'($urandom);
      MemReady = 1'b0;
      exp_q.push_back(s);
      tick();
    end
    Eq       = eq;
    MemReady = is_wait ? 1'b1 : 1'($urandom);
    e.count  = m_count;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic do_fetch();
    vec_t e;
    e = blank(0);
    e.memread = 1'b1; e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcwrite = 1'b1;
    step(e, 1'b1, -1, 1'($urandom));
  endtask

  task automatic do_decode(input logic [5:0] op);
    vec_t e;
    e = blank(1);
    e.alusrcb = 2'b11;
    e.illegal = !is_legal(op);
    step(e, 1'b0, 0, 1'($urandom));
  endtask

  task automatic do_memadr();
    vec_t e;
    e = blank(2);
    e.alusrca = 1'b1; e.alusrcb = 2'b10;
    step(e, 1'b0, 0, 1'($urandom));
  endtask

  // Whole instruction as a sequence of steps; the count advances after the final one.
  task automatic run_instr(input logic [5:0] op, input bit eq, input int mem_stalls);
    vec_t e;
    Op = op;
    do_fetch();
    do_decode(op);
    if (!is_legal(op)) return;
    case (op)
      6'd35: begin
        do_memadr();
        e = blank(3); e.memread = 1'b1; e.iord = 1'b1;
        step(e, 1'b1, mem_stalls, 1'($urandom));
        e = blank(4); e.regwrite = 1'b1; e.memtoreg = 1'b1;
        step(e, 1'b0, 0, 1'($urandom));
      end
      6'd43: begin
        do_memadr();
        e = blank(5); e.memwrite = 1'b1; e.iord = 1'b1;
        step(e, 1'b1, mem_stalls, 1'($urandom));
      end
      6'd0: begin
        e = blank(6); e.alusrca = 1'b1; e.aluop = 3'd1;
        step(e, 1'b0, 0, 1'($urandom));
        e = blank(7); e.regwrite = 1'b1; e.regdst = 1'b1;
        step(e, 1'b0, 0, 1'($urandom));
      end
      6'd4: begin
        e = blank(8); e.alusrca = 1'b1; e.pcsrc = 2'b01; e.pcwrite = eq;
        step(e, 1'b0, 0, eq);
      end
      6'd2: begin
        e = blank(11); e.pcsrc = 2'b10; e.pcwrite = 1'b1;
        step(e, 1'b0, 0, 1'($urandom));
      end
      default: begin
        e = blank(9); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        case (op)
          6'd10:   e.aluop = 3'd3;
          6'd12:   e.aluop = 3'd4;
          6'd13:   e.aluop = 3'd5;
          default: e.aluop = 3'd2;
        endcase
        e.zeroext = (op == 6'd12) || (op == 6'd13);
        step(e, 1'b0, 0, 1'($urandom));
        e = blank(10); e.regwrite = 1'b1;
        step(e, 1'b0, 0, 1'($urandom));
      end
    endcase
    m_count = m_count + 4'd1;
  endtask

  // LW aborted by a two-cycle reset while waiting in MEMRD.
  task automatic reset_mid_lw();
    vec_t e;
    Op = 6'd35;
    do_fetch();
    do_decode(6'd35);
    do_memadr();
    reset    = 1'b1;
    MemReady = 1'b1;
    e = blank(3); e.iord = 1'b1;
    exp_q.push_back(e);
    tick();
    m_count = 4'd0;
    e = blank(0); e.alusrcb = 2'b01;
    exp_q.push_back(e);
    tick();
    reset = 1'b0;
  endtask

  localparam int NOPS = 9;
  logic [5:0] legal_ops [NOPS] = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43};

  initial begin
    vec_t e;
    logic [5:0] op;
    reset    = 1'b1;
    Op       = 6'd0;
    Eq       = 1'b0;
    MemReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e = blank(0); e.alusrcb = 2'b01;
    exp_q.push_back(e);
    tick();
    reset = 1'b0;

    run_instr(6'd0, 1'b0, 0);
    run_instr(6'd35, 1'b0, 3);
    run_instr(6'd4, 1'b1, 0);
    run_instr(6'd4, 1'b0, 0);
    run_instr(6'd12, 1'b0, 0);
    run_instr(6'd13, 1'b0, 0);
    run_instr(6'd10, 1'b0, 0);
    run_instr(6'd8, 1'b0, 0);
    run_instr(6'd63, 1'b0, 0);
    run_instr(6'd43, 1'b0, 2);
    run_instr(6'd2, 1'b0, 0);
    reset_mid_lw();
    run_instr(6'd0, 1'b0, 0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, NOPS - 1)];
      run_instr(op, 1'($urandom), -1);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
